// File: rtl/oflow_registration_set_scheduler.sv
// ---------------------------------------------------------------------------
// oflow_registration_set_scheduler
//
// Runs the registration phase of one frame across the PE array. The frame's
// objects are split into sets of NUM_PE. For each set the block fires one
// start_registration pulse per active PE and one not_start_registration pulse
// per idle PE. It then waits for done_registration from every active PE, and
// a per-set watchdog aborts the frame if a PE never answers.
//
// Ports
//   clk                     clock
//   reset_N                 asynchronous active-low reset
//   start_frame             1-cycle pulse, begin a frame (only honoured in IDLE)
//   num_of_objects [OBJ_W]  object count, sampled with start_frame
//   done_registration [NUM_PE]  per-PE completion pulses
//   start_registration [NUM_PE]     per-PE start pulse for the active PEs of a set
//   not_start_registration [NUM_PE] per-PE pulse, same cycle, for the idle PEs
//   num_of_sets [SET_W]     ceil(num_of_objects/NUM_PE), held until next frame
//   set_idx [SET_W]         index of the set in progress (holds after DONE)
//   busy                    high while the frame is in progress
//   done_frame              1-cycle pulse when all sets finished or aborted
//   timeout_err             sticky watchdog flag, cleared by next accepted frame
// ---------------------------------------------------------------------------
module oflow_registration_set_scheduler #(
  parameter int NUM_PE  = 24,
  parameter int OBJ_W   = 7,
  parameter int SET_W   = 4,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              start_frame,
  input  logic [OBJ_W-1:0]  num_of_objects,
  input  logic [NUM_PE-1:0] done_registration,
  output logic [NUM_PE-1:0] start_registration,
  output logic [NUM_PE-1:0] not_start_registration,
  output logic [SET_W-1:0]  num_of_sets,
  output logic [SET_W-1:0]  set_idx,
  output logic              busy,
  output logic              done_frame,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_LAUNCH, S_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [OBJ_W-1:0]  obj_q, obj_d;
  logic [OBJ_W-1:0]  remaining_q, remaining_d;
  logic [SET_W-1:0]  set_idx_q, set_idx_d;
  logic [SET_W-1:0]  num_sets_q, num_sets_d;
  logic [NUM_PE-1:0] active_mask_q, active_mask_d;
  logic [NUM_PE-1:0] done_seen_q, done_seen_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              timeout_err_q, timeout_err_d;
  logic              busy_q, busy_d;
  logic              done_frame_q, done_frame_d;
  logic [NUM_PE-1:0] start_reg_q, start_reg_d;
  logic [NUM_PE-1:0] not_start_q, not_start_d;

  logic [NUM_PE-1:0] done_hit;
  logic              set_complete;
  logic              wd_expired;
  logic              last_set;
  logic [OBJ_W-1:0]  rem_after;
  logic [SET_W-1:0]  sets_calc;
  logic [OBJ_W-1:0]  launch_rem;
  logic [NUM_PE-1:0] launch_mask;

  // Done pulses from PEs outside the current set are masked off here.
  assign done_hit     = done_registration & active_mask_q;
  assign set_complete = ((done_seen_q | done_hit) == active_mask_q);
  assign wd_expired   = (wd_q == TO_W'(TIMEOUT));
  assign last_set     = (set_idx_q == (num_sets_q - SET_W'(1)));
  assign sets_calc    = SET_W'((32'(obj_q) + NUM_PE - 1) / NUM_PE);

  // Saturating subtract: the final set may be partial.
  assign rem_after = (32'(remaining_q) >= NUM_PE) ? OBJ_W'(32'(remaining_q) - NUM_PE)
                                                  : '0;

  // A LAUNCH is only entered from CALC (first set) or NEXT (later sets), so
  // the object count still to be launched is selected without going through
  // remaining_d, which keeps the mask logic free of block-level loops.
  assign launch_rem = (state_q == S_CALC) ? obj_q : rem_after;

  // Thermometer mask: PE gi is active when more than gi objects remain.
  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_mask
    assign launch_mask[gi] = (32'(launch_rem) > 32'(gi));
  end

  // State register
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_frame) state_d = S_CALC;
      S_CALC:   state_d = (obj_q == '0) ? S_DONE : S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        // Completion is tested first so it wins over a same-cycle expiry.
        if (set_complete)    state_d = S_NEXT;
        else if (wd_expired) state_d = S_DONE;
      end
      S_NEXT:   state_d = last_set ? S_DONE : S_LAUNCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    obj_d         = obj_q;
    remaining_d   = remaining_q;
    set_idx_d     = set_idx_q;
    num_sets_d    = num_sets_q;
    active_mask_d = active_mask_q;
    done_seen_d   = done_seen_q;
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
    busy_d        = (state_d != S_IDLE);
    done_frame_d  = 1'b0;
    start_reg_d   = '0;
    not_start_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (start_frame) begin
          obj_d         = num_of_objects;
          timeout_err_d = 1'b0;
        end
      end
      S_CALC: begin
        num_sets_d  = sets_calc;
        set_idx_d   = '0;
        remaining_d = obj_q;
      end
      S_WAIT: begin
        done_seen_d = done_seen_q | done_hit;
        if (!set_complete) begin
          if (wd_expired) timeout_err_d = 1'b1;
          else            wd_d = wd_q + TO_W'(1);
        end
      end
      S_NEXT: begin
        remaining_d = rem_after;
        if (!last_set) set_idx_d = set_idx_q + SET_W'(1);
      end
      default: ;
    endcase

    // Pulses are registered, so they are produced on entry to their state.
    if (state_d == S_LAUNCH) begin
      active_mask_d = launch_mask;
      start_reg_d   = launch_mask;
      not_start_d   = ~launch_mask;
      done_seen_d   = '0;
      wd_d          = '0;
    end
    if (state_d == S_DONE) done_frame_d = 1'b1;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      obj_q         <= '0;
      remaining_q   <= '0;
      set_idx_q     <= '0;
      num_sets_q    <= '0;
      active_mask_q <= '0;
      done_seen_q   <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      done_frame_q  <= 1'b0;
      start_reg_q   <= '0;
      not_start_q   <= '0;
    end else begin
      obj_q         <= obj_d;
      remaining_q   <= remaining_d;
      set_idx_q     <= set_idx_d;
      num_sets_q    <= num_sets_d;
      active_mask_q <= active_mask_d;
      done_seen_q   <= done_seen_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      done_frame_q  <= done_frame_d;
      start_reg_q   <= start_reg_d;
      not_start_q   <= not_start_d;
    end
  end

  assign start_registration     = start_reg_q;
  assign not_start_registration = not_start_q;
  assign num_of_sets            = num_sets_q;
  assign set_idx                = set_idx_q;
  assign busy                   = busy_q;
  assign done_frame             = done_frame_q;
  assign timeout_err            = timeout_err_q;

endmodule

// File: tb/tb_oflow_registration_set_scheduler.sv
module tb_oflow_registration_set_scheduler;
  localparam int NUM_PE  = 4;
  localparam int OBJ_W   = 7;
  localparam int SET_W   = 6;
  localparam int TIMEOUT = 15;
  localparam int TO_W    = 4;

  logic              clk = 1'b0;
  logic              reset_N = 1'b0;
  logic              start_frame = 1'b0;
  logic [OBJ_W-1:0]  num_of_objects = '0;
  logic [NUM_PE-1:0] done_registration = '0;
  logic [NUM_PE-1:0] start_registration;
  logic [NUM_PE-1:0] not_start_registration;
  logic [SET_W-1:0]  num_of_sets;
  logic [SET_W-1:0]  set_idx;
  logic              busy;
  logic              done_frame;
  logic              timeout_err;

  oflow_registration_set_scheduler #(
    .NUM_PE(NUM_PE), .OBJ_W(OBJ_W), .SET_W(SET_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk),
    .reset_N(reset_N),
    .start_frame(start_frame),
    .num_of_objects(num_of_objects),
    .done_registration(done_registration),
    .start_registration(start_registration),
    .not_start_registration(not_start_registration),
    .num_of_sets(num_of_sets),
    .set_idx(set_idx),
    .busy(busy),
    .done_frame(done_frame),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [NUM_PE-1:0] st; logic [NUM_PE-1:0] ns; int idx; } launch_t;
  typedef struct { int sets; logic err; int idx; } frame_t;

  launch_t lq[$];
  frame_t  fq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pe_delay[NUM_PE];
  int due[NUM_PE];
  logic [NUM_PE-1:0] extra = '0;
  logic              sf_pend = 1'b0;
  logic [OBJ_W-1:0]  obj_pend = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: observe outputs at the falling edge, run scoreboard + PE model,
  // then drive inputs for the next rising edge.
  task automatic step();
    launch_t lr;
    frame_t  fr;
    @(negedge clk);
    cyc++;
    if (reset_N) begin
      if ((start_registration | not_start_registration) != '0) begin
        if (lq.size() == 0) begin
          chk("launch_unexpected", 32'({start_registration, not_start_registration}), 32'(0));
        end else begin
          lr = lq.pop_front();
          chk("start_mask", 32'(start_registration), 32'(lr.st));
          chk("not_start_mask", 32'(not_start_registration), 32'(lr.ns));
          chk("launch_set_idx", 32'(set_idx), 32'(lr.idx));
          $display("launch cyc=%0d set=%0d start=%b not_start=%b", cyc, set_idx,
                   start_registration, not_start_registration);
        end
      end
      if (done_frame) begin
        if (fq.size() == 0) begin
          chk("frame_unexpected", 32'(done_frame), 32'(0));
        end else begin
          fr = fq.pop_front();
          chk("frame_num_sets", 32'(num_of_sets), 32'(fr.sets));
          chk("frame_timeout_err", 32'(timeout_err), 32'(fr.err));
          chk("frame_set_idx", 32'(set_idx), 32'(fr.idx));
          $display("done_frame cyc=%0d sets=%0d err=%0b idx=%0d", cyc, num_of_sets,
                   timeout_err, set_idx);
        end
      end
      for (int i = 0; i < NUM_PE; i++)
        if (start_registration[i] && pe_delay[i] > 0) due[i] = cyc + pe_delay[i];
    end
    for (int i = 0; i < NUM_PE; i++) done_registration[i] = (due[i] == cyc) | extra[i];
    extra          = '0;
    start_frame    = sf_pend;
    num_of_objects = obj_pend;
    sf_pend        = 1'b0;
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3);
    pe_delay[0] = d0; pe_delay[1] = d1; pe_delay[2] = d2; pe_delay[3] = d3;
    for (int i = 0; i < NUM_PE; i++) due[i] = -1;
  endtask

  // Reference model: expected launches and frame result for n objects,
  // optionally aborting at set to_set.
  task automatic push_frame(input int n, input int to_set);
    int rem, sets, cnt;
    launch_t lr;
    frame_t  fr;
    logic [31:0] m;
    rem  = n;
    sets = (n + NUM_PE - 1) / NUM_PE;
    for (int s = 0; s < sets; s++) begin
      cnt = (rem < NUM_PE) ? rem : NUM_PE;
      m   = (32'd1 << cnt) - 32'd1;
      lr.st  = m[NUM_PE-1:0];
      lr.ns  = ~m[NUM_PE-1:0];
      lr.idx = s;
      lq.push_back(lr);
      rem -= cnt;
      if (s == to_set) break;
    end
    fr.sets = sets;
    fr.err  = (to_set >= 0);
    fr.idx  = (to_set >= 0) ? to_set : ((sets == 0) ? 0 : sets - 1);
    fq.push_back(fr);
  endtask

  task automatic begin_frame(input int n, input int to_set, output int t);
    push_frame(n, to_set);
    sf_pend  = 1'b1;
    obj_pend = OBJ_W'(n);
    step();
    t = cyc;
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (done_frame) begin
        dc = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t;
    int dc;
    set_delays(0, 0, 0, 0);

    // Reset state
    step(); step();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done_frame", 32'(done_frame), 32'(0));
    chk("rst_start", 32'(start_registration), 32'(0));
    chk("rst_not_start", 32'(not_start_registration), 32'(0));
    chk("rst_num_sets", 32'(num_of_sets), 32'(0));
    chk("rst_set_idx", 32'(set_idx), 32'(0));
    chk("rst_timeout_err", 32'(timeout_err), 32'(0));
    reset_N = 1'b1;
    step(); step();

    // Zero objects: done_frame two cycles after start, busy on both cycles
    begin_frame(0, -1, t);
    step();
    chk("zero_busy_t1", 32'(busy), 32'(1));
    chk("zero_done_t1", 32'(done_frame), 32'(0));
    step();
    chk("zero_done_t2", 32'(done_frame), 32'(1));
    chk("zero_busy_t2", 32'(busy), 32'(1));
    step();
    chk("zero_busy_t3", 32'(busy), 32'(0));
    chk("zero_done_t3", 32'(done_frame), 32'(0));

    // Ten objects, every PE answers 3 cycles after its start
    set_delays(3, 3, 3, 3);
    begin_frame(10, -1, t);
    wait_done(60, dc);
    chk("ten_obj_latency", 32'(dc - t), 32'(17));
    step();
    chk("ten_obj_idle", 32'(busy), 32'(0));

    // Staggered completion inside one set
    set_delays(2, 5, 3, 9);
    begin_frame(4, -1, t);
    wait_done(60, dc);
    chk("stagger_latency", 32'(dc - t), 32'(13));
    step();

    // Spurious done from idle PEs must be ignored
    set_delays(4, 6, 0, 0);
    begin_frame(2, -1, t);
    step(); step();
    extra = 4'b1000;
    step();
    extra = 4'b1100;
    step();
    wait_done(60, dc);
    chk("spurious_latency", 32'(dc - t), 32'(10));
    step();

    // Watchdog abort: PE2 never answers
    set_delays(3, 3, 0, 3);
    begin_frame(4, 0, t);
    wait_done(60, dc);
    chk("wd_abort_latency", 32'(dc - t), 32'(19));
    step();
    chk("wd_err_sticky", 32'(timeout_err), 32'(1));
    chk("wd_idle", 32'(busy), 32'(0));

    // PE2 answers exactly when the watchdog reaches its limit: completion wins
    set_delays(3, 3, 16, 3);
    begin_frame(4, -1, t);
    step();
    chk("wd_err_cleared", 32'(timeout_err), 32'(0));
    wait_done(60, dc);
    chk("wd_edge_latency", 32'(dc - t), 32'(20));
    step();
    chk("wd_edge_no_err", 32'(timeout_err), 32'(0));

    // start_frame while busy is ignored
    set_delays(2, 2, 2, 2);
    begin_frame(5, -1, t);
    step(); step();
    sf_pend  = 1'b1;
    obj_pend = OBJ_W'(1);
    step();
    wait_done(60, dc);
    chk("busy_start_latency", 32'(dc - t), 32'(10));
    step(); step(); step();
    chk("busy_start_no_refire", 32'(busy), 32'(0));
    chk("busy_start_sets_held", 32'(num_of_sets), 32'(2));

    // Asynchronous reset in the middle of WAIT
    set_delays(0, 0, 0, 0);
    begin_frame(8, -1, t);
    step(); step(); step(); step(); step();
    chk("pre_rst_busy", 32'(busy), 32'(1));
    reset_N = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_num_sets", 32'(num_of_sets), 32'(0));
    chk("async_rst_set_idx", 32'(set_idx), 32'(0));
    chk("async_rst_masks", 32'({start_registration, not_start_registration}), 32'(0));
    lq.delete();
    fq.delete();
    step(); step();
    reset_N = 1'b1;
    step(); step(); step();
    chk("post_rst_busy", 32'(busy), 32'(0));
    chk("post_rst_done", 32'(done_frame), 32'(0));

    // Fresh frame after reset
    set_delays(2, 2, 2, 2);
    begin_frame(3, -1, t);
    wait_done(60, dc);
    chk("fresh_latency", 32'(dc - t), 32'(6));
    step(); step();

    chk("launch_queue_drained", 32'(lq.size()), 32'(0));
    chk("frame_queue_drained", 32'(fq.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
